// File: rtl/mem_access_unit.sv
// Load/store sequencer: turns SB/SH into read-modify-write word accesses and aligns/extends loads.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  stall,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  ld_valid,
  output logic                  misalign,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);

  typedef enum logic [2:0] {IDLE, RD, LD_OUT, RMW_RD, RMW_WR, ST_WR, MIS} state_t;

  state_t                state_q, state_d;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [DATA_W-1:0]     wd_q;
  logic [DATA_W-1:0]     ld_data_q, ld_data_d;

  logic       accept;
  logic       byte_op, half_op, mis_det;
  logic [1:0] o;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic [DATA_W-1:0] ext, merged;

  assign accept    = req_valid & (state_q == IDLE);
  assign req_ready = (state_q == IDLE);
  assign stall     = req_valid & ((state_q != IDLE) | MemRead | MemWrite);
  assign mem_a     = {addr_q[DM_ADDRESS-1:2], 2'b00};
  assign o         = addr_q[1:0];

  // Store Funct3 1xx is treated as SW, so the byte/half decode only applies to stores with bit 2 clear.
  assign byte_op = (Funct3[1:0] == 2'b00) & (MemRead | ~Funct3[2]);
  assign half_op = (Funct3[1:0] == 2'b01) & (MemRead | ~Funct3[2]);

`ifdef MISALIGN_TRAP_EN
  assign mis_det = (half_op & addr[0]) | (~byte_op & ~half_op & (addr[1:0] != 2'b00));
`else
  assign mis_det = 1'b0;
`endif

  always_comb begin
    lane_b = mem_rd[{o, 3'b000} +: 8];
    lane_h = o[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (f3_q)
      3'b000:  ext = {{(DATA_W-8){lane_b[7]}}, lane_b};
      3'b100:  ext = {{(DATA_W-8){1'b0}}, lane_b};
      3'b001:  ext = {{(DATA_W-16){lane_h[15]}}, lane_h};
      3'b101:  ext = {{(DATA_W-16){1'b0}}, lane_h};
      default: ext = mem_rd;
    endcase
    merged = mem_rd;
    if (!f3_q[0])  merged[{o, 3'b000} +: 8] = wd_q[7:0];
    else if (o[1]) merged[31:16] = wd_q[15:0];
    else           merged[15:0]  = wd_q[15:0];
  end

  always_comb begin
    state_d   = state_q;
    ld_data_d = ld_data_q;
    ld_data   = ld_data_q;
    ld_valid  = 1'b0;
    misalign  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wd    = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (MemRead)       state_d = mis_det ? MIS : RD;
          else if (MemWrite) state_d = mis_det ? MIS : ((byte_op | half_op) ? RMW_RD : ST_WR);
        end
      end
      RD: begin
        mem_re  = 1'b1;
        state_d = LD_OUT;
      end
      // Result is visible combinationally in this cycle and held in ld_data_q afterwards.
      LD_OUT: begin
        ld_valid  = 1'b1;
        ld_data   = ext;
        ld_data_d = ext;
        state_d   = IDLE;
      end
      RMW_RD: begin
        mem_re  = 1'b1;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        mem_we  = 1'b1;
        mem_wd  = merged;
        state_d = IDLE;
      end
      ST_WR: begin
        mem_we  = 1'b1;
        mem_wd  = wd_q;
        state_d = IDLE;
      end
      MIS: begin
        misalign = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      f3_q      <= '0;
      wd_q      <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_data_q <= ld_data_d;
      if (accept) begin
        addr_q <= addr;
        f3_q   <= Funct3;
        wd_q   <= wd;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a word-wide memory model.
// Define MISALIGN_TRAP_EN for both bench and RTL to exercise the trap build.
module tb_mem_access_unit;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, MemRead, MemWrite;
  logic [2:0]    Funct3;
  logic [AW-1:0] addr, mem_a;
  logic [DW-1:0] wd, ld_data, mem_wd, mem_rd;
  logic          stall, ld_valid, misalign, mem_re, mem_we;

  mem_access_unit #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .addr(addr), .wd(wd),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign),
    .mem_a(mem_a), .mem_re(mem_re), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory model with a bench-side preload port.
  logic [DW-1:0] mem [128];
  logic          pre_we = 1'b0;
  logic [6:0]    pre_a = '0;
  logic [DW-1:0] pre_d = '0;
  always @(posedge clk) begin
    if (pre_we)      mem[pre_a] <= pre_d;
    else if (mem_we) mem[mem_a[8:2]] <= mem_wd;
    if (mem_re) mem_rd <= mem[mem_a[8:2]];
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a[8:2]; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  int          re_c, we_c, lv_c, mis_c, rdy_c;
  logic        both, a_moved, stall0;
  logic [8:0]  a_cap;
  logic [31:0] ld_cap, wd_cap;

  task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                    input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; MemRead = ld; MemWrite = st; Funct3 = f3; addr = a; wd = d;
    #1 stall0 = stall;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    re_c = -1; we_c = -1; lv_c = -1; mis_c = -1; rdy_c = -1;
    both = 1'b0; a_moved = 1'b0; a_cap = mem_a; ld_cap = '0; wd_cap = '0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_re && re_c < 0) re_c = c;
      if (mem_we && we_c < 0) begin we_c = c; wd_cap = mem_wd; end
      if (ld_valid && lv_c < 0) begin lv_c = c; ld_cap = ld_data; end
      if (misalign && mis_c < 0) mis_c = c;
      if (req_ready && rdy_c < 0) rdy_c = c;
      if (mem_re && mem_we) both = 1'b1;
      if (rdy_c < 0 && mem_a != a_cap) a_moved = 1'b1;
    end
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] init;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];
  logic        got;
  logic [31:0] cap;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = '0; addr = '0; wd = '0;

    vecs[0]  = '{1'b1, 1'b0, 3'b000, 9'h013, 32'h0,        32'h80FF1234, 32'hFFFFFF80};
    vecs[1]  = '{1'b1, 1'b0, 3'b100, 9'h013, 32'h0,        32'h80FF1234, 32'h00000080};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 9'h012, 32'h0,        32'h80FF1234, 32'hFFFF80FF};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 9'h010, 32'h0,        32'h80FF1234, 32'h00001234};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        32'h80FF1234, 32'h80FF1234};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 9'h011, 32'h0,        32'h80FF1234, 32'h00000012};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 9'h022, 32'h000000AB, 32'h11223344, 32'h11AB3344};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 9'h020, 32'hFFFFFF55, 32'h11223344, 32'h11223355};
    vecs[8]  = '{1'b0, 1'b1, 3'b001, 9'h006, 32'h0000BEEF, 32'hDEAD0000, 32'hBEEF0000};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 9'h004, 32'h1234ABCD, 32'hDEAD0000, 32'hDEADABCD};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 9'h040, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 1'b1, 3'b111, 9'h044, 32'h01020304, 32'hFFFFFFFF, 32'h01020304};
    vecs[12] = '{1'b1, 1'b1, 3'b011, 9'h048, 32'h0,        32'h12345678, 32'h12345678};
    vecs[13] = '{1'b1, 1'b0, 3'b100, 9'h04A, 32'h0,        32'h12345678, 32'h00000034};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_strobes", {29'b0, mem_re, mem_we, ld_valid}, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {28'b0, req_ready, stall, misalign, mem_re}, 32'h8);

    for (int i = 0; i < 14; i++) begin
      logic rmw;
      rmw = vecs[i].st && !vecs[i].ld && (vecs[i].f3 == 3'b000 || vecs[i].f3 == 3'b001);
      preload(vecs[i].a, vecs[i].init);
      op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd);
      chk($sformatf("v%0d_stall_accept", i), {31'b0, stall0}, 32'h1);
      chk($sformatf("v%0d_mem_a", i), {23'b0, a_cap}, {23'b0, vecs[i].a[8:2], 2'b00});
      chk($sformatf("v%0d_a_held_no_overlap", i), {30'b0, a_moved, both}, 32'h0);
      if (vecs[i].ld) begin
        chk($sformatf("v%0d_timing", i), {re_c[7:0], we_c[7:0], lv_c[7:0], rdy_c[7:0]},
            {8'd1, 8'hFF, 8'd2, 8'd3});
        chk($sformatf("v%0d_ld_data", i), ld_cap, vecs[i].exp);
        chk($sformatf("v%0d_ld_hold", i), ld_data, vecs[i].exp);
      end else begin
        if (rmw)
          chk($sformatf("v%0d_timing", i), {re_c[7:0], we_c[7:0], lv_c[7:0], rdy_c[7:0]},
              {8'd1, 8'd2, 8'hFF, 8'd3});
        else
          chk($sformatf("v%0d_timing", i), {re_c[7:0], we_c[7:0], lv_c[7:0], rdy_c[7:0]},
              {8'hFF, 8'd1, 8'hFF, 8'd2});
        chk($sformatf("v%0d_mem_wd", i), wd_cap, vecs[i].exp);
        chk($sformatf("v%0d_mem_word", i), mem[vecs[i].a[8:2]], vecs[i].exp);
      end
    end

    // SH then LH at the same address.
    preload(9'h006, 32'hDEAD0000);
    op(1'b0, 1'b1, 3'b001, 9'h006, 32'h0000BEEF);
    op(1'b1, 1'b0, 3'b001, 9'h006, 32'h0);
    chk("sh_lh_readback", ld_cap, 32'hFFFFBEEF);

    // Request with neither MemRead nor MemWrite: no stall, no access.
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b010; addr = 9'h010;
    #1 chk("noop_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    chk("noop_idle", {29'b0, req_ready, mem_re, mem_we}, 32'h4);
    req_valid = 1'b0;

    // SW immediately followed by a stalled LW at the same address.
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010;
    addr = 9'h040; wd = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1;
    #1 chk("b2b_stall_busy", {29'b0, stall, mem_we, req_ready}, 32'h6);
    @(negedge clk);
    chk("b2b_ready_stall", {30'b0, req_ready, stall}, 32'h3);
    @(negedge clk);
    req_valid = 1'b0; MemRead = 1'b0;
    chk("b2b_lw_read", {31'b0, mem_re}, 32'h1);
    got = 1'b0; cap = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ld_valid) begin got = 1'b1; cap = ld_data; break; end
    end
    chk("b2b_ld_valid_seen", {31'b0, got}, 32'h1);
    chk("b2b_ld_data", cap, 32'hCAFEF00D);

`ifdef MISALIGN_TRAP_EN
    op(1'b1, 1'b0, 3'b010, 9'h041, 32'h0);
    chk("mis_lw_timing", {mis_c[7:0], re_c[7:0], we_c[7:0], rdy_c[7:0]},
        {8'd1, 8'hFF, 8'hFF, 8'd2});
    preload(9'h004, 32'h55667788);
    op(1'b0, 1'b1, 3'b001, 9'h005, 32'h0000BEEF);
    chk("mis_sh_timing", {mis_c[7:0], re_c[7:0], we_c[7:0], rdy_c[7:0]},
        {8'd1, 8'hFF, 8'hFF, 8'd2});
    chk("mis_sh_no_write", mem[1], 32'h55667788);
`else
    preload(9'h040, 32'hA5A51234);
    op(1'b1, 1'b0, 3'b010, 9'h041, 32'h0);
    chk("unaligned_lw_timing", {mis_c[7:0], re_c[7:0], lv_c[7:0], rdy_c[7:0]},
        {8'hFF, 8'd1, 8'd2, 8'd3});
    chk("unaligned_lw_data", ld_cap, 32'hA5A51234);
    op(1'b1, 1'b0, 3'b001, 9'h043, 32'h0);
    chk("unaligned_lh_data", ld_cap, 32'hFFFFA5A5);
`endif

    // Reset in the middle of an SB write cycle.
    preload(9'h020, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b000;
    addr = 9'h022; wd = 32'h000000AB;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk("rmw_we_before_rst", {31'b0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1 chk("rst_async_we_drop", {31'b0, mem_we}, 32'h0);
    chk("rst_async_ready", {31'b0, req_ready}, 32'h1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_release_ld_data", ld_data, 32'h0);
    chk("rst_write_dropped", mem[8], 32'h11223344);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
